// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchroniser, majority filter, oversampled FSM, valid/ready output.
// Define UART_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-word FIFO.
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_out_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_err_o,
  output logic                 break_det_o,
  output logic                 busy_o
);

  localparam int TICKS_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TICKS     = (TICKS_RAW < 1) ? 1 : TICKS_RAW;
  localparam int TW        = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int CW        = $clog2(OVERSAMPLE);
  localparam int BW        = $clog2(DATA_BITS + 1);
  localparam int WW        = DATA_BITS + 2;

  if (OVERSAMPLE < 4 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0 ||
      DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2) begin : g_bad_cfg
    $error("uart_rx_cfg: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK
  } state_t;

  // Input conditioning: 2-flop synchroniser feeding a 3-sample majority vote
  logic [1:0] sync_q;
  logic [2:0] filt_q;
  logic       rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      filt_q <= '1;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      filt_q <= {filt_q[1:0], sync_q[1]};
    end
  end

  assign rx_s = (filt_q[0] & filt_q[1]) | (filt_q[0] & filt_q[2]) | (filt_q[1] & filt_q[2]);

  // Free-running sample tick generator
  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  assign tick = (tick_cnt_q == TW'(TICKS - 1));

  always_ff @(posedge clk) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
  end

  // Receive FSM
  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [BW-1:0]          bit_idx_q;
  logic [DATA_BITS-1:0]   sh_q;
  logic                   par_bit_q;
  logic                   par_err_q;
  logic                   stop_idx_q;
  logic                   stop_low_q;
  logic                   stop_high_q;
  logic                   brk_q;

  logic                   samp;
  logic                   last_stop;
  logic                   is_break;
  logic                   word_done;
  logic [WW-1:0]          word_d;

  assign samp      = tick && (cnt_q == CW'(OVERSAMPLE - 1));
  assign last_stop = (state_q == S_STOP) && samp && (stop_idx_q == 1'(STOP_BITS - 1));
  // A break is an all-zero frame: data, parity bit and every stop sample low
  assign is_break  = (sh_q == '0) && ((PARITY == 0) || !par_bit_q) && !stop_high_q && !rx_s;
  assign word_done = last_stop && !is_break;
  assign word_d    = {stop_low_q | !rx_s, par_err_q, sh_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      par_bit_q   <= 1'b0;
      par_err_q   <= 1'b0;
      stop_idx_q  <= 1'b0;
      stop_low_q  <= 1'b0;
      stop_high_q <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      brk_q <= last_stop && is_break;
      if (tick) begin
        case (state_q)
          S_IDLE: begin
            if (!rx_s) begin
              state_q <= S_START;
              cnt_q   <= '0;
            end
          end
          S_START: begin
            if (cnt_q == CW'(OVERSAMPLE / 2 - 1)) begin
              cnt_q <= '0;
              if (!rx_s) begin
                state_q     <= S_DATA;
                bit_idx_q   <= '0;
                par_bit_q   <= 1'b0;
                par_err_q   <= 1'b0;
                stop_idx_q  <= 1'b0;
                stop_low_q  <= 1'b0;
                stop_high_q <= 1'b0;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_DATA: begin
            if (samp) begin
              cnt_q <= '0;
              sh_q  <= {rx_s, sh_q[DATA_BITS-1:1]};
              if (bit_idx_q == BW'(DATA_BITS - 1)) state_q <= (PARITY != 0) ? S_PAR : S_STOP;
              else                                 bit_idx_q <= bit_idx_q + BW'(1);
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_PAR: begin
            if (samp) begin
              cnt_q     <= '0;
              par_bit_q <= rx_s;
              par_err_q <= ((^sh_q) ^ rx_s) != (PARITY == 1);
              state_q   <= S_STOP;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_STOP: begin
            if (samp) begin
              cnt_q       <= '0;
              stop_low_q  <= stop_low_q | !rx_s;
              stop_high_q <= stop_high_q | rx_s;
              if (last_stop) state_q <= is_break ? S_BRK : S_IDLE;
              else           stop_idx_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_BRK: begin
            if (rx_s) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign break_det_o = brk_q;
  assign busy_o      = (state_q != S_IDLE);

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q;
  logic          ovr_q;
  logic          full, empty, push, pop;
  logic [WW-1:0] head;

  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = !empty && data_ready_i;
  // A full FIFO still accepts a word when the consumer pops in the same cycle
  assign push  = word_done && (!full || pop);
  assign head  = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= word_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      ovr_q   <= word_done && full && !pop;
    end
  end

  assign data_valid_o  = !empty;
  assign data_out_o    = empty ? '0 : head[DATA_BITS-1:0];
  assign parity_err_o  = !empty && head[DATA_BITS];
  assign frame_err_o   = !empty && head[DATA_BITS+1];
  assign overrun_err_o = ovr_q;
`else
  logic [WW-1:0] hold_q;
  logic          valid_q;
  logic          ovr_q;
  logic          pop, load;

  assign pop  = valid_q && data_ready_i;
  assign load = word_done && (!valid_q || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (load) begin
        hold_q  <= word_d;
        valid_q <= 1'b1;
      end else if (pop) begin
        valid_q <= 1'b0;
      end
      ovr_q <= word_done && valid_q && !pop;
    end
  end

  assign data_valid_o  = valid_q;
  assign data_out_o    = hold_q[DATA_BITS-1:0];
  assign parity_err_o  = hold_q[DATA_BITS];
  assign frame_err_o   = hold_q[DATA_BITS+1];
  assign overrun_err_o = ovr_q;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1 instance (a) and even-parity instance (b).
// CLK_FREQ is scaled down so one bit is 256 clk, keeping the run short.
module tb_uart_rx_cfg;
  localparam int CLK_FREQ = 2_457_600;
  localparam int BAUD     = 9600;
  localparam int BIT      = (CLK_FREQ / (BAUD * 16)) * 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       rdy_a = 1'b1, rdy_b = 1'b1;
  logic [7:0] dout_a, dout_b;
  logic       dv_a, dv_b, fe_a, fe_b, pe_a, pe_b, ovr_a, ovr_b, brk_a, brk_b, busy_a, busy_b;

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_dut_a (
    .clk(clk), .rst(rst), .rx_i(rx_a), .data_out_o(dout_a), .data_valid_o(dv_a),
    .data_ready_i(rdy_a), .frame_err_o(fe_a), .parity_err_o(pe_a),
    .overrun_err_o(ovr_a), .break_det_o(brk_a), .busy_o(busy_a));

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY(2)) u_dut_b (
    .clk(clk), .rst(rst), .rx_i(rx_b), .data_out_o(dout_b), .data_valid_o(dv_b),
    .data_ready_i(rdy_b), .frame_err_o(fe_b), .parity_err_o(pe_b),
    .overrun_err_o(ovr_b), .break_det_o(brk_b), .busy_o(busy_b));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Handshake / pulse monitors
  int         acc_a = 0, brkc_a = 0, ovrc_a = 0, acc_b = 0;
  logic [7:0] last_a = '0, last_b = '0;
  logic       lfe_a = 1'b0, lpe_a = 1'b0, lpe_b = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (dv_a && rdy_a) begin
        acc_a++; last_a = dout_a; lfe_a = fe_a; lpe_a = pe_a;
      end
      if (dv_b && rdy_b) begin
        acc_b++; last_b = dout_b; lpe_b = pe_b;
      end
      if (brk_a) brkc_a++;
      if (ovr_a) ovrc_a++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit which, input logic v, input int n);
    if (which) rx_b = v; else rx_a = v;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d, input bit has_par,
                            input logic p, input logic stop);
    drive(which, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(which, d[i], BIT);
    if (has_par) drive(which, p, BIT);
    drive(which, stop, BIT);
    drive(which, 1'b1, 2 * BIT);
  endtask

  int acc0, brk0;

  initial begin
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end
    chk("rst_valid", 32'(dv_a), 0);
    chk("rst_data", 32'(dout_a), 0);
    chk("rst_flags", 32'({fe_a, pe_a, ovr_a, brk_a}), 0);
    chk("rst_busy", 32'(busy_a), 0);
    rst = 1'b0;
    drive(0, 1'b1, 20);

    // Plain 8N1 frame
    acc0 = acc_a;
    send_frame(0, 8'h55, 0, 1'b0, 1'b1);
    chk("55_count", 32'(acc_a - acc0), 1);
    chk("55_data", 32'(last_a), 32'h55);
    chk("55_flags", 32'({lfe_a, lpe_a}), 0);

    // Even parity: 0xA3 has four ones, so correct parity bit is 0
    send_frame(1, 8'hA3, 1, 1'b1, 1'b1);
    chk("par_bad_data", 32'(last_b), 32'hA3);
    chk("par_bad_flag", 32'(lpe_b), 1);
    send_frame(1, 8'hA3, 1, 1'b0, 1'b1);
    chk("par_ok_count", 32'(acc_b), 2);
    chk("par_ok_flag", 32'(lpe_b), 0);

    // Low stop bit is flagged, next good frame is clean
    send_frame(0, 8'h3C, 0, 1'b0, 1'b0);
    chk("fe_data", 32'(last_a), 32'h3C);
    chk("fe_flag", 32'(lfe_a), 1);
    send_frame(0, 8'h96, 0, 1'b0, 1'b1);
    chk("fe_next_data", 32'(last_a), 32'h96);
    chk("fe_next_flag", 32'({lfe_a, lpe_a}), 0);

    // Line break: 12 bit times low
    acc0 = acc_a; brk0 = brkc_a;
    drive(0, 1'b0, 12 * BIT);
    chk("brk_busy_hold", 32'(busy_a), 1);
    chk("brk_pulses", 32'(brkc_a - brk0), 1);
    drive(0, 1'b1, 2 * BIT);
    chk("brk_no_data", 32'(acc_a - acc0), 0);
    chk("brk_busy_rel", 32'(busy_a), 0);

    // Short low glitch is rejected at mid start bit
    acc0 = acc_a;
    drive(0, 1'b0, 60);
    drive(0, 1'b1, 2 * BIT);
    chk("glitch_no_data", 32'(acc_a - acc0), 0);
    chk("glitch_idle", 32'(busy_a), 0);

    // Reset in the middle of 0x81, then 0x42
    acc0 = acc_a;
    drive(0, 1'b0, BIT);
    drive(0, 1'b1, BIT);
    drive(0, 1'b0, BIT / 2);
    rst = 1'b1;
    drive(0, 1'b1, 3);
    chk("midrst_busy", 32'(busy_a), 0);
    rst = 1'b0;
    drive(0, 1'b1, 2 * BIT);
    send_frame(0, 8'h42, 0, 1'b0, 1'b1);
    chk("midrst_count", 32'(acc_a - acc0), 1);
    chk("midrst_data", 32'(last_a), 32'h42);

    // Overrun: consumer stalled, second word dropped
    acc0 = acc_a; brk0 = ovrc_a;
    rdy_a = 1'b0;
    send_frame(0, 8'h11, 0, 1'b0, 1'b1);
    send_frame(0, 8'h22, 0, 1'b0, 1'b1);
    chk("ovr_valid", 32'(dv_a), 1);
    chk("ovr_held", 32'(dout_a), 32'h11);
    chk("ovr_pulses", 32'(ovrc_a - brk0), 1);
    rdy_a = 1'b1;
    drive(0, 1'b1, 3);
    chk("ovr_pop_count", 32'(acc_a - acc0), 1);
    chk("ovr_pop_data", 32'(last_a), 32'h11);
    chk("ovr_empty", 32'(dv_a), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
